// File: rtl/mdl_bram_mover.sv
// Command-driven block RAM sequencer: copies a region (read on port A, write on port B)
// or fills a region with a constant, one word per cycle.
module mdl_bram_mover #(
  parameter int PRM_DRAM = 32,
  parameter int PRM_ADDR = 12
) (
  input  logic                iSYS_CLK,
  input  logic                iSYS_RST_N,
  input  logic                iSTART,
  input  logic                iMODE,
  input  logic [PRM_ADDR-1:0] iSRC,
  input  logic [PRM_ADDR-1:0] iDST,
  input  logic [PRM_ADDR:0]   iLEN,
  input  logic [PRM_DRAM-1:0] iFILL,
  input  logic                iABORT,
  output logic                oBUSY,
  output logic                oDONE,
  output logic                oEN_A,
  output logic                oWE_A,
  output logic [PRM_ADDR-1:0] oADR_A,
  input  logic [PRM_DRAM-1:0] iDOUT_A,
  output logic                oEN_B,
  output logic                oWE_B,
  output logic [PRM_ADDR-1:0] oADR_B,
  output logic [PRM_DRAM-1:0] oDIN_B
);

  typedef enum logic [2:0] {IDLE, RD, DRN, FILL, FIN} state_t;

  localparam logic [PRM_ADDR-1:0] ADDR_ONE = {{(PRM_ADDR-1){1'b0}}, 1'b1};
  localparam logic [PRM_ADDR:0]   LEN_ONE  = {{PRM_ADDR{1'b0}}, 1'b1};

  state_t              state;
  logic [PRM_ADDR-1:0] rd_addr;
  logic [PRM_ADDR-1:0] wr_addr;
  logic [PRM_ADDR:0]   left;
  logic                desc;
  logic                aborted;
  logic                sel_dout;
  logic [PRM_DRAM-1:0] fill_val;
  logic [PRM_DRAM-1:0] din_q;
  logic [PRM_ADDR-1:0] len_m1;
  logic                desc_start;

  assign len_m1     = iLEN[PRM_ADDR-1:0] - ADDR_ONE;
  assign desc_start = !iMODE && (iDST > iSRC);
  assign oWE_A      = 1'b0;

  // Copy writes forward the RAM read data straight through so each word lands one cycle after its read.
  assign oDIN_B = sel_dout ? iDOUT_A : din_q;

  always_ff @(posedge iSYS_CLK or negedge iSYS_RST_N) begin
    if (!iSYS_RST_N) begin
      state    <= IDLE;
      oBUSY    <= 1'b0;
      oDONE    <= 1'b0;
      oEN_A    <= 1'b0;
      oADR_A   <= '0;
      oEN_B    <= 1'b0;
      oWE_B    <= 1'b0;
      oADR_B   <= '0;
      din_q    <= '0;
      sel_dout <= 1'b0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      left     <= '0;
      desc     <= 1'b0;
      aborted  <= 1'b0;
      fill_val <= '0;
    end else begin
      case (state)
        IDLE: begin
          oBUSY    <= 1'b0;
          oDONE    <= 1'b0;
          oEN_A    <= 1'b0;
          oEN_B    <= 1'b0;
          oWE_B    <= 1'b0;
          sel_dout <= 1'b0;
          aborted  <= 1'b0;
          if (iSTART) begin
            fill_val <= iFILL;
            left     <= iLEN;
            desc     <= desc_start;
            // Descending copies start at the top of both regions so overlaps are safe.
            if (desc_start) begin
              rd_addr <= iSRC + len_m1;
              wr_addr <= iDST + len_m1;
            end else begin
              rd_addr <= iSRC;
              wr_addr <= iDST;
            end
            if (iLEN == '0)  state <= FIN;
            else if (iMODE)  state <= FILL;
            else             state <= RD;
          end
        end
        RD: begin
          oBUSY    <= 1'b1;
          oEN_A    <= 1'b1;
          oADR_A   <= rd_addr;
          rd_addr  <= desc ? rd_addr - ADDR_ONE : rd_addr + ADDR_ONE;
          oEN_B    <= oEN_A;
          oWE_B    <= oEN_A;
          sel_dout <= 1'b1;
          if (oEN_A) begin
            oADR_B  <= wr_addr;
            wr_addr <= desc ? wr_addr - ADDR_ONE : wr_addr + ADDR_ONE;
          end
          left <= left - LEN_ONE;
          if (left == LEN_ONE || iABORT) begin
            state   <= DRN;
            aborted <= iABORT;
          end
        end
        DRN: begin
          oBUSY    <= 1'b1;
          oEN_A    <= 1'b0;
          oEN_B    <= 1'b1;
          oWE_B    <= 1'b1;
          oADR_B   <= wr_addr;
          sel_dout <= 1'b1;
          state    <= (aborted || iABORT) ? IDLE : FIN;
        end
        FILL: begin
          oBUSY    <= 1'b1;
          oEN_B    <= 1'b1;
          oWE_B    <= 1'b1;
          oADR_B   <= wr_addr;
          wr_addr  <= wr_addr + ADDR_ONE;
          din_q    <= fill_val;
          sel_dout <= 1'b0;
          left     <= left - LEN_ONE;
          if (iABORT)               state <= IDLE;
          else if (left == LEN_ONE) state <= FIN;
        end
        FIN: begin
          oBUSY    <= 1'b0;
          oDONE    <= 1'b1;
          oEN_A    <= 1'b0;
          oEN_B    <= 1'b0;
          oWE_B    <= 1'b0;
          sel_dout <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdl_bram_mover.sv
// Bench for mdl_bram_mover: drives commands into a behavioural dual-port RAM and compares
// memory contents and cycle timing against a word-level reference model.
module tb_mdl_bram_mover;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [11:0] src;
  logic [11:0] dst;
  logic [12:0] len;
  logic [31:0] fill;
  logic        abort_in;
  logic        busy;
  logic        done;
  logic        en_a;
  logic        we_a;
  logic [11:0] adr_a;
  logic [31:0] dout_a;
  logic        en_b;
  logic        we_b;
  logic [11:0] adr_b;
  logic [31:0] din_b;

  logic        pre_we;
  logic [11:0] pre_adr;
  logic [31:0] pre_dat;

  logic [31:0] mem     [0:4095];
  logic [31:0] exp_mem [0:4095];
  logic [31:0] snap    [0:4095];

  int checks;
  int errors;
  int done_cyc, done_cnt, rd_cnt, wr_cnt, rd_first, rd_last, wr_first, wr_last;
  int busy_err, clash_cnt, we_a_err;
  logic [11:0] rd_q[$];
  logic [11:0] wr_q[$];

  mdl_bram_mover #(.PRM_DRAM(32), .PRM_ADDR(12)) dut (
    .iSYS_CLK(clk), .iSYS_RST_N(rst_n), .iSTART(start), .iMODE(mode),
    .iSRC(src), .iDST(dst), .iLEN(len), .iFILL(fill), .iABORT(abort_in),
    .oBUSY(busy), .oDONE(done), .oEN_A(en_a), .oWE_A(we_a), .oADR_A(adr_a),
    .iDOUT_A(dout_a), .oEN_B(en_b), .oWE_B(we_b), .oADR_B(adr_b), .oDIN_B(din_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous dual-port RAM; the preload port is only used while the mover is idle.
  always @(posedge clk) begin
    if (en_a) dout_a <= mem[adr_a];
    if (en_b && we_b) mem[adr_b] <= din_b;
    else if (pre_we) mem[pre_adr] <= pre_dat;
  end

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_adr = a; pre_dat = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    exp_mem[a] = d;
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  task automatic model_copy(input logic [11:0] s, input logic [11:0] d, input int first, input int count);
    for (int i = 0; i < 4096; i++) snap[i] = exp_mem[i];
    for (int i = first; i < first + count; i++) exp_mem[d + 12'(i)] = snap[s + 12'(i)];
  endtask

  task automatic model_fill(input logic [11:0] d, input int count, input logic [31:0] f);
    for (int i = 0; i < count; i++) exp_mem[d + 12'(i)] = f;
  endtask

  // Leaves the bench 1 time unit after edge 0, the edge that samples the strobe.
  task automatic start_cmd(input logic m, input logic [11:0] s, input logic [11:0] d,
                           input logic [12:0] l, input logic [31:0] f);
    @(negedge clk);
    mode = m; src = s; dst = d; len = l; fill = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Observes cycles 1..exp_end+2; busy is expected high exactly in cycles below exp_end.
  task automatic watch(input int exp_end, input int abort_at, input int junk_at);
    done_cyc = -1; done_cnt = 0; rd_cnt = 0; wr_cnt = 0;
    rd_first = -1; rd_last = -1; wr_first = -1; wr_last = -1;
    busy_err = 0; clash_cnt = 0; we_a_err = 0;
    rd_q.delete(); wr_q.delete();
    for (int cyc = 1; cyc <= exp_end + 2; cyc++) begin
      abort_in = (cyc == abort_at);
      if (cyc == junk_at) begin
        start = 1'b1; mode = ~mode; src = 12'h000; dst = 12'h500; len = 13'd5;
      end
      @(posedge clk); #1;
      abort_in = 1'b0; start = 1'b0;
      if (en_a) begin
        rd_cnt++; rd_q.push_back(adr_a);
        if (rd_first < 0) rd_first = cyc;
        rd_last = cyc;
      end
      if (en_b && we_b) begin
        wr_cnt++; wr_q.push_back(adr_b);
        if (wr_first < 0) wr_first = cyc;
        wr_last = cyc;
      end
      if (en_a && en_b && adr_a == adr_b) clash_cnt++;
      if (we_a !== 1'b0) we_a_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy !== 1'(cyc < exp_end)) busy_err++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if ({en_a, en_b, we_b, we_a} !== 4'b0) begin errors++; $display("[TB] FAIL reset_enables: got %b expected 0000", {en_a, en_b, we_b, we_a}); end
    checks++; if ({adr_a, adr_b} !== 24'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 000000", {adr_a, adr_b}); end
    checks++; if (din_b !== 32'h0) begin errors++; $display("[TB] FAIL reset_din: got %h expected 00000000", din_b); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_copy_ascending();
    int bad;
    for (int i = 0; i < 8; i++) poke(12'h010 + 12'(i), 32'(i + 1));
    start_cmd(1'b0, 12'h010, 12'h100, 13'd8, 32'h0);
    watch(10, 0, 0);
    model_copy(12'h010, 12'h100, 0, 8);
    checks++; if (done_cyc !== 10 || done_cnt !== 1) begin errors++; $display("[TB] FAIL copy_asc_done: got cycle %0d count %0d expected cycle 10 count 1", done_cyc, done_cnt); end
    checks++; if (rd_cnt !== 8 || rd_first !== 1 || rd_last !== 8) begin errors++; $display("[TB] FAIL copy_asc_reads: got %0d reads in %0d..%0d expected 8 in 1..8", rd_cnt, rd_first, rd_last); end
    checks++; if (wr_cnt !== 8 || wr_first !== 2 || wr_last !== 9) begin errors++; $display("[TB] FAIL copy_asc_writes: got %0d writes in %0d..%0d expected 8 in 2..9", wr_cnt, wr_first, wr_last); end
    checks++; if (busy_err !== 0 || we_a_err !== 0) begin errors++; $display("[TB] FAIL copy_asc_busy: got %0d busy and %0d we_a errors expected 0", busy_err, we_a_err); end
    bad = 0;
    for (int i = 0; i < 8; i++) if (mem[12'h100 + 12'(i)] !== 32'(i + 1)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL copy_asc_data: got %0d wrong words expected 0", bad); end
    checks++; if (mem_diff() !== 0) begin errors++; $display("[TB] FAIL copy_asc_mem: got %0d differing words expected 0", mem_diff()); end
  endtask

  task automatic test_copy_overlap();
    logic [11:0] exp_wr;
    logic [11:0] exp_rd;
    int bad;
    for (int i = 0; i < 4; i++) poke(12'h020 + 12'(i), 32'hA + 32'(i));
    start_cmd(1'b0, 12'h020, 12'h022, 13'd4, 32'h0);
    watch(6, 0, 0);
    model_copy(12'h020, 12'h022, 0, 4);
    bad = (wr_q.size() != 4 || rd_q.size() != 4) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      exp_wr = 12'h025 - 12'(i);
      exp_rd = 12'h023 - 12'(i);
      if (i < wr_q.size() && wr_q[i] !== exp_wr) bad++;
      if (i < rd_q.size() && rd_q[i] !== exp_rd) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL copy_ovl_order: got %0d order errors expected 0 (descending)", bad); end
    checks++; if (clash_cnt !== 0) begin errors++; $display("[TB] FAIL copy_ovl_clash: got %0d same-address cycles expected 0", clash_cnt); end
    checks++; if (done_cyc !== 6) begin errors++; $display("[TB] FAIL copy_ovl_done: got %0d expected 6", done_cyc); end
    bad = 0;
    for (int i = 0; i < 4; i++) if (mem[12'h022 + 12'(i)] !== 32'hA + 32'(i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL copy_ovl_data: got %0d wrong words expected 0", bad); end
    checks++; if (mem_diff() !== 0) begin errors++; $display("[TB] FAIL copy_ovl_mem: got %0d differing words expected 0", mem_diff()); end
  endtask

  task automatic test_fill_wrap();
    logic [31:0] keep;
    logic [11:0] exp_wr;
    int bad;
    keep = exp_mem[12'h002];
    start_cmd(1'b1, 12'h000, 12'hFFE, 13'd4, 32'hDEADBEEF);
    watch(5, 0, 0);
    model_fill(12'hFFE, 4, 32'hDEADBEEF);
    checks++; if (done_cyc !== 5 || done_cnt !== 1) begin errors++; $display("[TB] FAIL fill_wrap_done: got cycle %0d count %0d expected cycle 5 count 1", done_cyc, done_cnt); end
    bad = (wr_q.size() != 4) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      exp_wr = 12'hFFE + 12'(i);
      if (i < wr_q.size() && wr_q[i] !== exp_wr) bad++;
    end
    checks++; if (bad !== 0 || wr_first !== 1) begin errors++; $display("[TB] FAIL fill_wrap_addr: got %0d address errors first write %0d expected 0 and 1", bad, wr_first); end
    checks++; if (rd_cnt !== 0 || busy_err !== 0) begin errors++; $display("[TB] FAIL fill_wrap_ctrl: got %0d reads %0d busy errors expected 0 and 0", rd_cnt, busy_err); end
    checks++; if (mem[12'h002] !== keep) begin errors++; $display("[TB] FAIL fill_wrap_keep: got %h expected %h", mem[12'h002], keep); end
    checks++; if (mem_diff() !== 0) begin errors++; $display("[TB] FAIL fill_wrap_mem: got %0d differing words expected 0", mem_diff()); end
  endtask

  task automatic test_len_zero();
    start_cmd(1'b0, 12'h030, 12'h040, 13'd0, 32'h0);
    watch(1, 0, 0);
    checks++; if (done_cyc !== 1 || done_cnt !== 1) begin errors++; $display("[TB] FAIL len0_done: got cycle %0d count %0d expected cycle 1 count 1", done_cyc, done_cnt); end
    checks++; if (rd_cnt !== 0 || wr_cnt !== 0 || en_b !== 1'b0) begin errors++; $display("[TB] FAIL len0_enables: got %0d reads %0d writes expected 0 and 0", rd_cnt, wr_cnt); end
    checks++; if (busy_err !== 0) begin errors++; $display("[TB] FAIL len0_busy: got %0d busy errors expected 0", busy_err); end
  endtask

  task automatic test_full_depth();
    start_cmd(1'b0, 12'h123, 12'h123, 13'd4096, 32'h0);
    watch(4098, 0, 0);
    checks++; if (done_cyc !== 4098) begin errors++; $display("[TB] FAIL full_done: got %0d expected 4098", done_cyc); end
    checks++; if (rd_cnt !== 4096 || wr_cnt !== 4096) begin errors++; $display("[TB] FAIL full_count: got %0d reads %0d writes expected 4096 each", rd_cnt, wr_cnt); end
    checks++; if (wr_q.size() != 4096 || wr_q[0] !== 12'h123 || wr_q[4095] !== 12'h122) begin errors++; $display("[TB] FAIL full_span: got %0d writes expected 4096 from 123 to 122", wr_q.size()); end
    checks++; if (mem_diff() !== 0 || clash_cnt !== 0) begin errors++; $display("[TB] FAIL full_mem: got %0d differing words %0d clashes expected 0 and 0", mem_diff(), clash_cnt); end
  endtask

  task automatic test_abort();
    start_cmd(1'b0, 12'h300, 12'h200, 13'd16, 32'h0);
    watch(7, 5, 0);
    model_copy(12'h300, 12'h200, 0, 5);
    checks++; if (rd_cnt !== 5 || rd_first !== 1 || rd_last !== 5) begin errors++; $display("[TB] FAIL abort_reads: got %0d reads in %0d..%0d expected 5 in 1..5", rd_cnt, rd_first, rd_last); end
    checks++; if (wr_cnt !== 5 || wr_first !== 2 || wr_last !== 6) begin errors++; $display("[TB] FAIL abort_writes: got %0d writes in %0d..%0d expected 5 in 2..6", wr_cnt, wr_first, wr_last); end
    checks++; if (done_cnt !== 0) begin errors++; $display("[TB] FAIL abort_done: got %0d pulses expected 0", done_cnt); end
    checks++; if (busy_err !== 0) begin errors++; $display("[TB] FAIL abort_busy: got %0d busy errors expected 0 (low from cycle 7)", busy_err); end
    checks++; if (mem_diff() !== 0) begin errors++; $display("[TB] FAIL abort_mem: got %0d differing words expected 0", mem_diff()); end
  endtask

  task automatic test_ignored_start();
    logic [31:0] f;
    f = $urandom;
    start_cmd(1'b1, 12'h000, 12'h400, 13'd8, f);
    watch(9, 0, 3);
    model_fill(12'h400, 8, f);
    checks++; if (done_cyc !== 9 || done_cnt !== 1) begin errors++; $display("[TB] FAIL ign_start_done: got cycle %0d count %0d expected cycle 9 count 1", done_cyc, done_cnt); end
    checks++; if (wr_cnt !== 8 || rd_cnt !== 0) begin errors++; $display("[TB] FAIL ign_start_access: got %0d writes %0d reads expected 8 and 0", wr_cnt, rd_cnt); end
    checks++; if (mem_diff() !== 0) begin errors++; $display("[TB] FAIL ign_start_mem: got %0d differing words expected 0", mem_diff()); end
  endtask

  task automatic test_random();
    logic        m;
    int          l, s, d, exp_end;
    logic [31:0] f;
    for (int it = 0; it < 10; it++) begin
      m = 1'($urandom_range(0, 1));
      l = $urandom_range(1, 40);
      f = $urandom;
      if (m) begin
        s = 0;
        d = $urandom_range(0, 4095);
      end else begin
        s = $urandom_range(0, 4095 - l);
        if ($urandom_range(0, 1) == 1) d = s + $urandom_range(0, 12) - 6;
        else d = $urandom_range(0, 4095 - l);
        if (d < 0) d = 0;
        if (d > 4095 - l) d = 4095 - l;
      end
      exp_end = m ? l + 1 : l + 2;
      start_cmd(m, 12'(s), 12'(d), 13'(l), f);
      watch(exp_end, 0, 0);
      if (m) model_fill(12'(d), l, f);
      else model_copy(12'(s), 12'(d), 0, l);
      checks++; if (done_cyc !== exp_end || wr_cnt !== l) begin errors++; $display("[TB] FAIL rand%0d_timing: got done %0d writes %0d expected done %0d writes %0d", it, done_cyc, wr_cnt, exp_end, l); end
      checks++; if (mem_diff() !== 0 || clash_cnt !== 0 || busy_err !== 0) begin errors++; $display("[TB] FAIL rand%0d_mem: got %0d diffs %0d clashes %0d busy errors expected 0", it, mem_diff(), clash_cnt, busy_err); end
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] f;
    f = $urandom;
    start_cmd(1'b1, 12'h000, 12'h600, 13'd8, f);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, en_a, en_b, we_b} !== 5'b0 || {adr_a, adr_b} !== 24'h0 || din_b !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_outputs: got ctl %b adr %h din %h expected all 0", {busy, done, en_a, en_b, we_b}, {adr_a, adr_b}, din_b); end
    @(posedge clk); #1;
    checks++; if ({en_a, en_b, we_b} !== 3'b0) begin errors++; $display("[TB] FAIL rst_mid_hold: got %b expected 000", {en_a, en_b, we_b}); end
    model_fill(12'h600, 2, f);
    checks++; if (mem_diff() !== 0) begin errors++; $display("[TB] FAIL rst_mid_partial: got %0d differing words expected 0", mem_diff()); end
    @(negedge clk);
    rst_n = 1'b1;
    f = $urandom;
    start_cmd(1'b1, 12'h000, 12'h700, 13'd3, f);
    watch(4, 0, 0);
    model_fill(12'h700, 3, f);
    checks++; if (done_cyc !== 4 || done_cnt !== 1 || busy_err !== 0) begin errors++; $display("[TB] FAIL rst_mid_resume: got done %0d count %0d busy errors %0d expected 4 1 0", done_cyc, done_cnt, busy_err); end
    checks++; if (mem_diff() !== 0) begin errors++; $display("[TB] FAIL rst_mid_resume_mem: got %0d differing words expected 0", mem_diff()); end
  endtask

  initial begin
    checks = 0; errors = 0;
    start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill = '0; abort_in = 1'b0;
    pre_we = 1'b0; pre_adr = '0; pre_dat = '0;
    test_reset();
    $display("[TB] preloading memory");
    for (int i = 0; i < 4096; i++) poke(12'(i), $urandom);
    test_copy_ascending();
    test_copy_overlap();
    test_fill_wrap();
    test_len_zero();
    test_full_depth();
    test_abort();
    test_ignored_start();
    test_random();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
